// File: rtl/updi_break_seq.sv
// Programmable UPDI break-sequence generator: drives n low pulses of a latched
// break length separated by high gaps of a latched gap length, with abort and done.
module updi_break_seq #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_breaks,
  input  logic [LEN_W-1:0] break_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic             abort,
  output logic             busy,
  output logic             line,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] brk_q, brk_d;
  logic [LEN_W-1:0] blen_q, blen_d;
  logic [LEN_W-1:0] glen_q, glen_d;
  logic             busy_d, line_d, done_d;

  // A zero length is treated as one clock so the phase counter can never wrap.
  function automatic logic [LEN_W-1:0] clamp1(input logic [LEN_W-1:0] v);
    return (v == '0) ? LEN_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      brk_q   <= '0;
      blen_q  <= '0;
      glen_q  <= '0;
      busy    <= 1'b0;
      line    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      brk_q   <= brk_d;
      blen_q  <= blen_d;
      glen_q  <= glen_d;
      busy    <= busy_d;
      line    <= line_d;
      done    <= done_d;
    end
  end

  // Outputs are computed from the next state so they are registered yet
  // reflect the new phase in the same cycle the state register changes.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    brk_d   = brk_q;
    blen_d  = blen_q;
    glen_d  = glen_q;
    busy_d  = 1'b0;
    line_d  = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort && (n_breaks != '0)) begin
          state_d = BREAK;
          blen_d  = clamp1(break_len);
          glen_d  = clamp1(gap_len);
          phase_d = clamp1(break_len);
          brk_d   = n_breaks;
          busy_d  = 1'b1;
          line_d  = 1'b0;
        end
      end

      BREAK: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          brk_d   = '0;
        end else if (phase_q == LEN_W'(1)) begin
          if (brk_q == CNT_W'(1)) begin
            state_d = IDLE;
            phase_d = '0;
            brk_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            phase_d = glen_q;
            brk_d   = brk_q - CNT_W'(1);
            busy_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
          busy_d  = 1'b1;
          line_d  = 1'b0;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          phase_d = '0;
          brk_d   = '0;
        end else if (phase_q == LEN_W'(1)) begin
          state_d = BREAK;
          phase_d = blen_q;
          busy_d  = 1'b1;
          line_d  = 1'b0;
        end else begin
          phase_d = phase_q - LEN_W'(1);
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
        brk_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_updi_break_seq.sv
// Self-checking bench for updi_break_seq: table vectors, hand-written corner
// sequences and random traffic, all checked against a queue-based line model.
module tb_updi_break_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  n_breaks;
  logic [15:0] break_len;
  logic [15:0] gap_len;
  logic        abort;
  logic        busy, line, done;

  int tests = 0;
  int fails = 0;

  updi_break_seq #(.LEN_W(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .n_breaks(n_breaks),
    .break_len(break_len), .gap_len(gap_len), .abort(abort),
    .busy(busy), .line(line), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: on acceptance the whole expected line waveform is
  // expanded into a queue; each edge consumes one entry.
  bit   mq[$];
  logic m_busy = 1'b0;
  logic m_line = 1'b1;
  logic m_done = 1'b0;

  always @(posedge clk) begin
    int bb, gg;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_line = 1'b1; m_done = 1'b0;
    end else if (mq.size() != 0) begin
      if (abort) begin
        mq.delete();
        m_busy = 1'b0; m_line = 1'b1; m_done = 1'b0;
      end else begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy = 1'b0; m_line = 1'b1; m_done = 1'b1;
        end else begin
          m_busy = 1'b1; m_line = mq[0]; m_done = 1'b0;
        end
      end
    end else begin
      m_busy = 1'b0; m_line = 1'b1; m_done = 1'b0;
      if (start && !abort && n_breaks != 0) begin
        bb = (break_len == 0) ? 1 : int'(break_len);
        gg = (gap_len == 0) ? 1 : int'(gap_len);
        for (int i = 0; i < int'(n_breaks); i++) begin
          for (int j = 0; j < bb; j++) mq.push_back(1'b0);
          if (i < int'(n_breaks) - 1)
            for (int j = 0; j < gg; j++) mq.push_back(1'b1);
        end
        m_busy = 1'b1; m_line = mq[0];
      end
    end
  end

  typedef struct {
    logic [3:0]  n;
    logic [15:0] blen;
    logic [15:0] glen;
    int          abort_at;
    int          exp_busy;
    int          exp_low;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic applyStimulus(input logic s, input logic [3:0] n,
                               input logic [15:0] b, input logic [15:0] g,
                               input logic a);
    start = s; n_breaks = n; break_len = b; gap_len = g; abort = a;
  endtask

  task automatic checkOutput(input string tag);
    tests++;
    if ({busy, line, done} !== {m_busy, m_line, m_done}) begin
      fails++;
      $display("[TB] FAIL %s: busy/line/done got %b%b%b expected %b%b%b at %0t",
               tag, busy, line, done, m_busy, m_line, m_done, $time);
    end
  endtask

  task automatic checkValue(input string tag, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  // Runs one table vector while scrambling inputs and pulsing start mid-sequence.
  task automatic runVector(input vec_t v, input int idx);
    int busy_cnt = 0, low_cnt = 0, done_cnt = 0;
    string tag = $sformatf("vec%0d", idx);
    applyStimulus(1'b1, v.n, v.blen, v.glen, 1'b0);
    for (int c = 1; c <= v.exp_busy + 3; c++) begin
      stepCycle(tag);
      if (busy) busy_cnt++;
      if (busy && !line) low_cnt++;
      if (done) done_cnt++;
      applyStimulus((c < v.exp_busy) && (c % 3 == 1), 4'($urandom),
                    16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
                    c == v.abort_at);
    end
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    checkValue({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    checkValue({tag, "_low_cycles"}, low_cnt, v.exp_low);
    checkValue({tag, "_done_count"}, done_cnt, v.exp_done);
  endtask

  initial begin
    int busy_cnt, done_cnt;

    vecs[0] = '{n: 4'd2,  blen: 16'd10, glen: 16'd10, abort_at: -1, exp_busy: 30, exp_low: 20, exp_done: 1};
    vecs[1] = '{n: 4'd1,  blen: 16'd1,  glen: 16'd5,  abort_at: -1, exp_busy: 1,  exp_low: 1,  exp_done: 1};
    vecs[2] = '{n: 4'd3,  blen: 16'd0,  glen: 16'd0,  abort_at: -1, exp_busy: 5,  exp_low: 3,  exp_done: 1};
    vecs[3] = '{n: 4'd0,  blen: 16'd7,  glen: 16'd7,  abort_at: -1, exp_busy: 0,  exp_low: 0,  exp_done: 0};
    vecs[4] = '{n: 4'd3,  blen: 16'd4,  glen: 16'd2,  abort_at: -1, exp_busy: 16, exp_low: 12, exp_done: 1};
    vecs[5] = '{n: 4'd4,  blen: 16'd8,  glen: 16'd3,  abort_at: 14, exp_busy: 14, exp_low: 11, exp_done: 0};
    vecs[6] = '{n: 4'd15, blen: 16'd2,  glen: 16'd1,  abort_at: -1, exp_busy: 44, exp_low: 30, exp_done: 1};

    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset");
    checkValue("reset_busy", int'(busy), 0);
    checkValue("reset_line", int'(line), 1);
    rst = 1'b0;

    foreach (vecs[i]) runVector(vecs[i], i);

    // Abort together with start while idle: start must be ignored.
    applyStimulus(1'b1, 4'd2, 16'd5, 16'd5, 1'b1);
    stepCycle("abort_start");
    checkValue("abort_start_busy", int'(busy), 0);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    stepCycle("abort_start_after");
    checkValue("abort_start_busy2", int'(busy), 0);

    // Restart accepted in the done cycle, with no idle bubble.
    applyStimulus(1'b1, 4'd1, 16'd2, 16'd1, 1'b0);
    stepCycle("restart");
    checkValue("restart_first_line", int'(line), 0);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    stepCycle("restart");
    stepCycle("restart");
    checkValue("restart_done1", int'(done), 1);
    applyStimulus(1'b1, 4'd1, 16'd1, 16'd0, 1'b0);
    stepCycle("restart");
    checkValue("restart_busy2", int'({busy, line, done}), 3'b100);
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    stepCycle("restart");
    checkValue("restart_done2", int'({busy, line, done}), 3'b011);

    // Reset during a gap, then a fresh full sequence.
    applyStimulus(1'b1, 4'd2, 16'd3, 16'd4, 1'b0);
    stepCycle("rst_gap");
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    repeat (4) stepCycle("rst_gap");
    checkValue("rst_in_gap", int'({busy, line}), 2'b11);
    rst = 1'b1;
    stepCycle("rst_gap");
    checkValue("rst_outputs", int'({busy, line, done}), 3'b010);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd2, 16'd3, 16'd4, 1'b0);
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      stepCycle("rst_fresh");
      applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    checkValue("rst_fresh_busy", busy_cnt, 10);
    checkValue("rst_fresh_done", done_cnt, 1);

    // Random traffic: starts, aborts and input churn against the model.
    for (int it = 0; it < 25; it++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 6)), 16'($urandom_range(0, 6)),
                    16'($urandom_range(0, 6)), 1'b0);
      for (int c = 0; c < 60; c++) begin
        stepCycle("random");
        applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 6)),
                      16'($urandom_range(0, 6)), 16'($urandom_range(0, 6)),
                      $urandom_range(0, 15) == 0);
      end
    end
    applyStimulus(1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
    repeat (3) stepCycle("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updi_break_seq.md
# updi_break_seq

Programmable UPDI break-sequence generator, the successor to the fixed double-break block. On a start request it drives the UPDI line low for a runtime break length, then releases it for a runtime gap length, and repeats for a runtime number of breaks. It also supports abort and a completion strobe. It sits between the UPDI link controller and the pin driver, and is used for line resets and for recovering from lost synchronisation.

## Interface
- `LEN_W`, 16, width of the break/gap length inputs and of the phase counter
- `CNT_W`, 4, width of `n_breaks` and of the break counter; maximum breaks is 2^CNT_W-1
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  request; sampled only in IDLE
- `n_breaks`  in  CNT_W  number of break pulses; latched at accepted start
- `break_len`  in  LEN_W  clocks per break (line low); latched at start; 0 treated as 1
- `gap_len`  in  LEN_W  clocks per gap (line high) between breaks; latched at start; 0 treated as 1
- `abort`  in  1  terminate the sequence immediately
- `busy`  out  1  high while a sequence is in progress
- `line`  out  1  UPDI line level: 1 = released/idle, 0 = break
- `done`  out  1  one-cycle strobe when a sequence completes normally

## Operation
- States: IDLE, BREAK, GAP. All outputs are registered.
- Reset values: state=IDLE, `busy`=0, `line`=1, `done`=0, counters=0.
- Start acceptance:
  - In IDLE, `start`=1 with `n_breaks`≠0 → next state BREAK.
  - Latch `break_len`, `gap_len` and `n_breaks`.
  - Load the phase counter with the latched break length and the break counter with `n_breaks`.
- `start` with `n_breaks`=0 is ignored: no busy, no done.
- BREAK: `line`=0, `busy`=1. The phase counter decrements each clock. When the phase ends, the break counter decrements:
  - If breaks remain → GAP, with the phase counter reloaded from the latched gap length.
  - If none remain → IDLE and `done`=1 for one cycle.
- GAP: `line`=1, `busy`=1. When the phase ends → BREAK, with the phase counter reloaded from the latched break length.
- `start` while busy is ignored. Input changes while busy have no effect; only the latched values are used.
- Abort:
  - `abort`=1 while busy → next edge IDLE, `line`=1, `busy`=0, no `done`.
  - `abort` in IDLE has no effect.
  - `abort` and `start` in the same IDLE cycle → start is ignored (abort wins).
- `rst` overrides everything, including a sequence in progress. State returns to reset values on the next edge.

## Timing
- An accepted start at edge k gives `busy`=1 and `line`=0 visible from after edge k (zero-cycle latency into the first break).
- Each break lasts exactly max(`break_len`,1) cycles and each gap exactly max(`gap_len`,1) cycles, counted in rising edges.
- Total busy cycles = n·B + (n−1)·G, where n = `n_breaks`, B = max(`break_len`,1) and G = max(`gap_len`,1).
- There is no gap after the final break. `busy` falls and `done` rises on the same edge. `done` is high for exactly one cycle, with `line`=1.
- A new start can be accepted in the cycle `done` is high, since the block is already IDLE. Its sequence begins at that edge.
- Phase transitions have no idle bubble: the cycle after the last break cycle is the first gap cycle, and vice versa.
- Counter widths: the phase counter is LEN_W bits and the break counter is CNT_W bits. No wrap-around is possible because lengths of 0 are clamped to 1.

## Test plan
- Double break: `n_breaks`=2, `break_len`=10, `gap_len`=10 → line low 10, high 10, low 10 cycles. Busy high for 30 cycles, then `done` for 1 cycle.
- Single short: `n_breaks`=1, `break_len`=1, `gap_len`=5 → line low 1 cycle, no gap, busy for 1 cycle, `done` on the next edge.
- Zero clamping and no-op: `break_len`=0, `gap_len`=0, `n_breaks`=3 → pattern 0,1,0,1,0 (5 busy cycles). Separately, `n_breaks`=0 → busy stays 0 and no `done`.
- Latching: start with `n_breaks`=3, `break_len`=4, `gap_len`=2. Change inputs and pulse `start` mid-sequence → sequence unchanged, 16 busy cycles, single `done`.
- Abort: `n_breaks`=4, `break_len`=8. Assert `abort` in cycle 3 of the second break → next edge `busy`=0, `line`=1, no `done`. Abort+start together in IDLE → stays idle.
- Reset mid-sequence: `rst`=1 during a gap → next edge all outputs at reset values. A start after reset runs a fresh full sequence.
